// File: rtl/adder_word_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_word_sequencer_if
//  Description : Request/response bundle for the multi-precision add/subtract
//                sequencer. The requester drives the operands and start; the
//                sequencer answers with busy/done and the final result.
//  Revision    : 1.0  initial release
// ============================================================================
interface adder_word_sequencer_if #(
    parameter int WORD_BITS = 4,
    parameter int NUM_WORDS = 4
);
    localparam int TOTAL_BITS = WORD_BITS * NUM_WORDS;

    // Request side
    logic                  start;
    logic                  sub;
    logic                  carry_in;
    logic [TOTAL_BITS-1:0] op_a;
    logic [TOTAL_BITS-1:0] op_b;

    // Response side
    logic                  busy;
    logic                  done;
    logic [TOTAL_BITS-1:0] result;
    logic                  carry_out;

    // Requester view
    modport master (
        output start,
        output sub,
        output carry_in,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  result,
        input  carry_out
    );

    // Sequencer view
    modport slave (
        input  start,
        input  sub,
        input  carry_in,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output result,
        output carry_out
    );
endinterface
`default_nettype wire

// File: rtl/adder_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adder_nbit
//  Description : Plain N-bit ripple adder with carry in and carry (overflow)
//                out. Shared by the word sequencer below.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  wire logic [BIT_WIDTH-1:0] i_a,
    input  wire logic [BIT_WIDTH-1:0] i_b,
    input  wire logic                 i_carry,
    output logic      [BIT_WIDTH-1:0] o_sum,
    output logic                      o_overflow
);
    // Widen by one bit so the carry out of the MSB lands in o_overflow.
    assign {o_overflow, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{BIT_WIDTH{1'b0}}, i_carry};
endmodule

// ============================================================================
//  Module      : adder_word_sequencer
//  Description : Multi-precision add/subtract controller. Runs one narrow
//                adder_nbit over NUM_WORDS slices of wide operands, least
//                significant slice first, one slice per clock, carrying the
//                slice carry through a register. Subtraction is A + ~B + 1.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_word_sequencer #(
    parameter int WORD_BITS = 4,
    parameter int NUM_WORDS = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    adder_word_sequencer_if.slave bus
);
    localparam int TOTAL_BITS = WORD_BITS * NUM_WORDS;
    localparam int IDX_BITS   = $clog2(NUM_WORDS);

    localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              r_state;

    // Latched operands, viewed as an array of slices so the active slice
    // can be picked directly by the slice index.
    logic [NUM_WORDS-1:0][WORD_BITS-1:0] r_a;
    logic [NUM_WORDS-1:0][WORD_BITS-1:0] r_b;
    logic [NUM_WORDS-1:0][WORD_BITS-1:0] r_work;
    logic [NUM_WORDS-1:0][WORD_BITS-1:0] w_work_next;

    logic [IDX_BITS-1:0]                 r_idx;
    logic                                r_carry;

    logic [WORD_BITS-1:0]                w_sum;
    logic                                w_overflow;

    logic                                r_busy;
    logic                                r_done;
    logic [TOTAL_BITS-1:0]               r_result;
    logic                                r_carry_out;

    // The single shared narrow adder, fed with the current slice.
    adder_nbit #(
        .BIT_WIDTH (WORD_BITS)
    ) u_adder (
        .i_a        (r_a[r_idx]),
        .i_b        (r_b[r_idx]),
        .i_carry    (r_carry),
        .o_sum      (w_sum),
        .o_overflow (w_overflow)
    );

    // Work register with the current slice sum merged in; used both to
    // update the work register and, on the last slice, to publish the
    // complete result in the same edge.
    always_comb begin
        w_work_next        = r_work;
        w_work_next[r_idx] = w_sum;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_work      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is folded into an add of the
                        // inverted subtrahend with a forced carry of one.
                        r_a     <= bus.op_a;
                        r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
                        r_carry <= bus.sub ? 1'b1 : bus.carry_in;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end

                S_ADD: begin
                    r_work  <= w_work_next;
                    r_carry <= w_overflow;
                    if (r_idx == c_last_idx) begin
                        r_result    <= w_work_next;
                        r_carry_out <= w_overflow;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here: a request
                    // arriving while busy is dropped, not queued.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
endmodule
`default_nettype wire

// File: tb/tb_adder_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_word_sequencer
//  Description : Self-checking bench for adder_word_sequencer
//                (WORD_BITS=4, NUM_WORDS=4): directed vector table, busy
//                and reset corner sequences, and randomized operations
//                checked against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_word_sequencer;
    localparam int WB = 4;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [15:0] prev_exp;

    always #5 clk = ~clk;

    adder_word_sequencer_if #(.WORD_BITS(WB), .NUM_WORDS(NW)) bus ();

    adder_word_sequencer #(
        .WORD_BITS (WB),
        .NUM_WORDS (NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] res;
        logic        cout;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: unsigned arithmetic on whole 16-bit values.
    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic ci);
        int ai = int'(a);
        int bi = int'(b);
        int r;
        logic [15:0] res;
        logic co;
        if (s) begin
            r   = (ai - bi + 65536) % 65536;
            co  = (ai >= bi);
        end else begin
            r   = ai + bi + int'(ci);
            co  = (r >= 65536);
            r   = r % 65536;
        end
        res = 16'(r);
        return {co, res};
    endfunction

    // One complete operation: handshake timing, result hold, and final value.
    // With protect set, start is held high with other operands during ADD
    // and DONE; otherwise the operand inputs are scrambled after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic ci, input bit protect,
                          input logic [15:0] exp_res, input logic exp_cout,
                          input string nm);
        bit          tim_ok = 1'b1;
        logic [15:0] obs_res = 16'h0;
        logic        obs_cout = 1'b0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.carry_in = ci;
        @(posedge clk);
        #1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy !== (k <= 4)) tim_ok = 1'b0;
            if (bus.done !== (k == 4)) tim_ok = 1'b0;
            if (k < 4 && bus.result !== prev_exp) tim_ok = 1'b0;
            if (k == 4) begin
                obs_res  = bus.result;
                obs_cout = bus.carry_out;
            end
            if (k == 5 && (bus.result !== obs_res || bus.carry_out !== obs_cout)) tim_ok = 1'b0;
            if (protect && k <= 4) begin
                bus.start    = 1'b1;
                bus.op_a     = 16'hAAAA;
                bus.op_b     = 16'h5555;
                bus.sub      = 1'b0;
                bus.carry_in = 1'b0;
            end else begin
                bus.start    = 1'b0;
                bus.op_a     = 16'($urandom);
                bus.op_b     = 16'($urandom);
                bus.sub      = 1'($urandom);
                bus.carry_in = 1'($urandom);
            end
        end
        chk({nm, "_timing"}, {31'd0, tim_ok}, 32'd1);
        chk({nm, "_result"}, {16'd0, obs_res}, {16'd0, exp_res});
        chk({nm, "_carry"},  {31'd0, obs_cout}, {31'd0, exp_cout});
        prev_exp = exp_res;
    endtask

    initial begin
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic        rs, rc;
        bit          no_done;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1};
        vecs[4] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.sub      = 1'b0;
        bus.carry_in = 1'b0;

        // Reset from unknown state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, bus.busy},      32'd0);
        chk("reset_done",   {31'd0, bus.done},      32'd0);
        chk("reset_result", {16'd0, bus.result},    32'd0);
        chk("reset_carry",  {31'd0, bus.carry_out}, 32'd0);
        rst      = 1'b0;
        prev_exp = 16'h0000;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0,
                   vecs[i].res, vecs[i].cout, $sformatf("vec%0d", i));
        end

        // Busy protection: extra starts during ADD/DONE are dropped
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, "protect");
        no_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h0002) no_done = 1'b0;
        end
        chk("protect_idle_hold", {31'd0, no_done}, 32'd1);

        // Reset asserted on the second ADD edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h00FF;
        bus.op_b  = 16'h0001;
        bus.sub   = 1'b0;
        bus.carry_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy",   {31'd0, bus.busy},      32'd0);
        chk("midrst_done",   {31'd0, bus.done},      32'd0);
        chk("midrst_result", {16'd0, bus.result},    32'd0);
        chk("midrst_carry",  {31'd0, bus.carry_out}, 32'd0);
        rst = 1'b0;
        no_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
        end
        chk("midrst_no_done", {31'd0, no_done}, 32'd1);
        prev_exp = 16'h0000;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, "after_rst");

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            m = ref_op(ra, rb, rs, rc);
            run_op(ra, rb, rs, rc, 1'b0, m[15:0], m[16], $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_word_sequencer.md
Name: adder_word_sequencer

Overview:
Multi-precision add/subtract controller. It time-multiplexes one existing adder_nbit instance (BIT_WIDTH = WORD_BITS) across NUM_WORDS word slices of wide operands, least-significant slice first, and chains the carry through a register between slices. A start/busy/done handshake lets wide arithmetic run on a narrow adder with one slice processed per clock.

Parameters:
WORD_BITS, 4, width of the shared adder_nbit instance; must be >= 1
NUM_WORDS, 4, number of slices per operation; must be >= 2
(derived) TOTAL_BITS = WORD_BITS*NUM_WORDS; IDX_BITS = clog2(NUM_WORDS)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = add, 1 = subtract (op_a - op_b); latched with start
carry_in  in  1  initial carry for add; ignored when sub=1
op_a  in  TOTAL_BITS  operand A; latched with start
op_b  in  TOTAL_BITS  operand B; latched with start
busy  out  1  high in ADD and DONE states
done  out  1  one-cycle pulse; result/carry_out valid from this cycle
result  out  TOTAL_BITS  final sum/difference, held until next completion
carry_out  out  1  final slice carry; for sub, 1 = no borrow (A >= B unsigned)

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. While rst is sampled high, the next edge forces state=IDLE and busy=0, done=0, result=0, carry_out=0, idx=0, carry_reg=0. This is the same regardless of state, including mid-operation. The aborted operation never pulses done.
- FSM states: IDLE, ADD, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - latch a_reg=op_a;
  - latch b_reg = op_b when sub=0, or ~op_b when sub=1;
  - carry_reg = carry_in when sub=0, or 1 when sub=1;
  - idx=0; go to ADD.
  - If start=0, stay in IDLE.
- ADD: the adder inputs are a_reg slice idx, b_reg slice idx, and carry_reg. Each edge:
  - write the adder sum into slice idx of the internal work register;
  - carry_reg <= adder overflow;
  - if idx == NUM_WORDS-1, copy the full work register (with the last slice) into result, set carry_out = adder overflow, go to DONE;
  - otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, busy=1; the next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle that begins NUM_WORDS edges after the start-sampling edge. Throughput is one operation per NUM_WORDS+2 cycles.
- start is ignored in ADD and DONE; it is neither queued nor allowed to alter the latched operands. Changes to op_a/op_b/sub/carry_in after the start-sampling edge have no effect.
- result and carry_out change only on the ADD->DONE edge or on reset. Partial slices are never visible on result.
- Arithmetic is unsigned modulo 2^TOTAL_BITS. Subtraction is two's complement (A + ~B + 1). No signed-overflow flag.
- Carry must ripple correctly across every slice boundary, including all-ones operands.

Test Plan:
(all cases WORD_BITS=4, NUM_WORDS=4)
1. Reset: hold rst=1 for 2 edges from unknown state -> busy=0, done=0, result=16'h0000, carry_out=0.
2. Add: op_a=16'h1234, op_b=16'h0FFF, carry_in=0, sub=0, start for 1 cycle -> done pulses exactly 4 edges after start edge, 1 cycle wide; result=16'h2233, carry_out=0; busy high for 5 cycles.
3. Full ripple: op_a=16'hFFFF, op_b=16'h0000, carry_in=1 -> result=16'h0000, carry_out=1. Then op_a=16'hFFFF, op_b=16'hFFFF, carry_in=1 -> result=16'hFFFF, carry_out=1.
4. Subtract: 16'h1000 - 16'h0001 with sub=1, carry_in=0 -> result=16'h0FFF, carry_out=1. Then 16'h0001 - 16'h0002 -> result=16'hFFFF, carry_out=0.
5. Busy protection: start 16'h0001+16'h0001, then assert start with 16'hAAAA+16'h5555 during ADD and in DONE; change op_a mid-op -> first result=16'h0002, exactly one done pulse, second request not executed. result holds 16'h0002 until a new start in IDLE.
6. Reset mid-op: start 16'h00FF+16'h0001 (result 16'h0100 initially), assert rst on the 2nd ADD edge -> next edge IDLE, busy=0, result=0, carry_out=0, no done pulse. A subsequent start completes normally.
